hilo_muldiv_unit: RTL

Multi-cycle HI/LO responder for the 32-bit MIPS datapath. Accepts multiply, multiply-accumulate, divide and move-to-HI/LO requests from the execute stage, and iterates them over 32 cycles. Holds the architectural HI and LO registers and serves MFHI/MFLO reads. Raises a stall while a result is pending.

---
 rtl/hilo_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Multi-cycle HI/LO unit for the 32-bit MIPS datapath. It holds the
// architectural HI and LO registers and executes MULT, MULTU, MADD and MSUB
// (and DIV/DIVU when enabled) iteratively, one step per cycle over ITER
// cycles. MTHI/MTLO write HI/LO directly in a single cycle.
//
// Configuration macro:
//   HILO_DIV_EN  - defined: DIV/DIVU use a restoring divider.
//                  undefined: the divider is omitted and DIV/DIVU are no-ops.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous, active-high reset
//   Start      request strobe, sampled at the rising edge
//   Op         000 MULT, 001 MULTU, 010 MADD, 011 MSUB,
//              100 DIV, 101 DIVU, 110 MTHI, 111 MTLO
//   A, B       rs / rt operands, sampled only at the accepting edge
//   Busy       high while an iterative operation is in flight
//   Done       one-cycle pulse in the first cycle a new HI/LO is visible
//   ReadStall  equals Busy; decode holds MFHI/MFLO while high
//   Rejected   Start & Busy (request dropped)
//   HiOut      current HI register
//   LoOut      current LO register
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             ReadStall,
  output logic             Rejected,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic [2:0]         op_q, op_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend/quotient shift register}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // Result (product or quotient) must be negated during FINISH.
  logic               neg_res_q, neg_res_d;

`ifdef HILO_DIV_EN
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   a_q, a_d;
`endif

  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_signed;

`ifdef HILO_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  // Only MULTU and DIVU are unsigned; everything else iterates on
  // magnitudes and fixes the sign at the end.
  always_comb begin
    op_signed = ~((Op == OP_MULTU) | (Op == OP_DIVU));
    a_neg     = op_signed & A[WIDTH-1];
    b_neg     = op_signed & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
  end

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole pair right once.
  always_comb begin
    mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_next    = {mul_sum, prod_q[WIDTH-1:1]};
    prod_signed = neg_res_q ? -prod_q : prod_q;
  end

`ifdef HILO_DIV_EN
  // Restoring divide step: shift the next dividend bit into the remainder
  // and keep the subtraction only when it does not go negative.
  always_comb begin
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_sub   = div_shift - {1'b0, mcand_q};
    div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 prod_q[WIDTH-2:0], div_ge};
    quot_fix  = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  end
`endif

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    op_d      = op_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
`ifdef HILO_DIV_EN
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    a_d        = a_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              op_d      = Op;
              mcand_d   = a_mag;
              prod_d    = {{WIDTH{1'b0}}, b_mag};
              neg_res_d = a_neg ^ b_neg;
            end
`ifdef HILO_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d    = S_RUN;
              cnt_d      = '0;
              op_d       = Op;
              mcand_d    = b_mag;
              prod_d     = {{WIDTH{1'b0}}, a_mag};
              neg_res_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              div_zero_d = (B == '0);
              a_d        = A;
            end
`endif
            default: ;
          endcase
        end
      end

      S_RUN: begin
`ifdef HILO_DIV_EN
        prod_d = op_q[2] ? div_next : mul_next;
`else
        prod_d = mul_next;
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_signed;
          OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_signed;
`ifdef HILO_DIV_EN
          OP_DIV, OP_DIVU: begin
            // Divide by zero returns all-ones quotient and the original A.
            if (div_zero_q) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = quot_fix;
              hi_d = rem_fix;
            end
          end
`endif
          default: {hi_d, lo_d} = prod_signed;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Single state register; reset aborts any in-flight operation.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      op_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
`ifdef HILO_DIV_EN
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
`ifdef HILO_DIV_EN
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      a_q        <= a_d;
`endif
    end
  end

  always_comb begin
    Busy      = (state_q != S_IDLE);
    ReadStall = Busy;
    Rejected  = Start & Busy;
    Done      = done_q;
    HiOut     = hi_q;
    LoOut     = lo_q;
  end

endmodule
